// File: rtl/xcvr_reset_seq_pkg.sv
// rtl/xcvr_reset_seq_pkg.sv - shared types, defaults and helpers for the transceiver reset sequencer
package xcvr_reset_pkg;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_MIN_RST_CYCLES = 100;
  localparam int DEF_TX_DIG_DLY     = 20;
  localparam int DEF_RX_LTD_DLY     = 4000;
  localparam int DEF_STAT_TIMEOUT   = 1000;

  typedef enum logic [2:0] {
    T_RESET, T_WAIT, T_ANA, T_DLY, T_DIG, T_RDY
  } tx_state_t;

  typedef enum logic [2:0] {
    R_RESET, R_WAIT, R_ANA, R_LTD, R_DIG, R_RDY
  } rx_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/xcvr_reset_seq_if.sv
// rtl/xcvr_reset_seq_if.sv - PHY reset/status bundle between the sequencer (master) and the PHY (slave)
interface xcvr_reset_seq_if;

  logic pll_locked;
  logic tx_rst_req;
  logic rx_rst_req;
  logic tx_cal_busy;
  logic rx_cal_busy;
  logic tx_analogreset_stat;
  logic tx_digitalreset_stat;
  logic rx_analogreset_stat;
  logic rx_digitalreset_stat;
  logic rx_is_lockedtodata;
  logic tx_analogreset;
  logic tx_digitalreset;
  logic rx_analogreset;
  logic rx_digitalreset;
  logic tx_ready;
  logic rx_ready;
  logic stat_err;

  modport master (
    input  pll_locked, tx_rst_req, rx_rst_req, tx_cal_busy, rx_cal_busy,
           tx_analogreset_stat, tx_digitalreset_stat,
           rx_analogreset_stat, rx_digitalreset_stat, rx_is_lockedtodata,
    output tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset,
           tx_ready, rx_ready, stat_err
  );

  modport slave (
    output pll_locked, tx_rst_req, rx_rst_req, tx_cal_busy, rx_cal_busy,
           tx_analogreset_stat, tx_digitalreset_stat,
           rx_analogreset_stat, rx_digitalreset_stat, rx_is_lockedtodata,
    input  tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset,
           tx_ready, rx_ready, stat_err
  );

endinterface

// File: rtl/xcvr_reset_seq_sync.sv
// rtl/xcvr_reset_seq_sync.sv - STAGES-deep single-bit synchroniser for PHY status inputs
module xcvr_reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/xcvr_reset_seq.sv
// rtl/xcvr_reset_seq.sv - TX/RX reset sequencer for one native PHY channel; optional XCVR_RST_STAT_TIMEOUT_EN
module xcvr_reset_seq
  import xcvr_reset_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int MIN_RST_CYCLES = DEF_MIN_RST_CYCLES,
  parameter int TX_DIG_DLY     = DEF_TX_DIG_DLY,
  parameter int RX_LTD_DLY     = DEF_RX_LTD_DLY,
  parameter int STAT_TIMEOUT   = DEF_STAT_TIMEOUT
) (
  input  logic              reconfig_clk,
  input  logic              reconfig_reset,
  xcvr_reset_seq_if.master  phy
);

  localparam int TW = clog2(max4(MIN_RST_CYCLES, TX_DIG_DLY, RX_LTD_DLY, STAT_TIMEOUT)) + 1;
  typedef logic [TW-1:0] tmr_t;

  localparam tmr_t MIN_LAST = tmr_t'(MIN_RST_CYCLES - 1);
  localparam tmr_t DIG_LOAD = tmr_t'(TX_DIG_DLY);
  localparam tmr_t LTD_LAST = tmr_t'(RX_LTD_DLY - 1);

  function automatic tmr_t sat_inc(input tmr_t v);
    return (v == '1) ? v : v + tmr_t'(1);
  endfunction

  logic [7:0] async_in;
  logic [7:0] sync_s;

  assign async_in = {phy.rx_is_lockedtodata, phy.rx_digitalreset_stat,
                     phy.rx_analogreset_stat, phy.tx_digitalreset_stat,
                     phy.tx_analogreset_stat, phy.rx_cal_busy,
                     phy.tx_cal_busy, phy.pll_locked};

  for (genvar g = 0; g < 8; g++) begin : g_sync
    xcvr_reset_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk_i (reconfig_clk),
      .rst_i (reconfig_reset),
      .d_i   (async_in[g]),
      .q_o   (sync_s[g])
    );
  end

  logic pll_s, tx_cal_s, rx_cal_s, tx_as_s, tx_ds_s, rx_as_s, rx_ds_s, ltd_s;
  assign {ltd_s, rx_ds_s, rx_as_s, tx_ds_s, tx_as_s, rx_cal_s, tx_cal_s, pll_s} = sync_s;

  tx_state_t tx_state_q, tx_state_d;
  rx_state_t rx_state_q, rx_state_d;
  tmr_t      tx_tmr_q, tx_tmr_d;
  tmr_t      rx_tmr_q, rx_tmr_d;
  logic      tx_ar_q, tx_dr_q, tx_ready_q;
  logic      rx_ar_q, rx_dr_q, rx_ready_q;
  logic      tx_abort, rx_ltd_loss;
  logic      tx_wd_to, rx_wd_to;

  assign tx_abort    = (tx_state_q != T_RESET) && (!pll_s || phy.tx_rst_req);
  assign rx_ltd_loss = (rx_state_q inside {R_DIG, R_RDY}) && !ltd_s;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tmr_d   = tx_tmr_q;
    if (tx_abort || tx_wd_to) begin
      tx_state_d = T_RESET;
      tx_tmr_d   = '0;
    end else begin
      case (tx_state_q)
        T_RESET: begin
          if (phy.tx_rst_req) begin
            tx_tmr_d = '0;
          end else if (tx_tmr_q == MIN_LAST) begin
            tx_state_d = T_WAIT;
            tx_tmr_d   = '0;
          end else begin
            tx_tmr_d = sat_inc(tx_tmr_q);
          end
        end
        T_WAIT: if (pll_s && !tx_cal_s && tx_as_s) tx_state_d = T_ANA;
        T_ANA: begin
          if (!tx_as_s) begin
            tx_state_d = T_DLY;
            tx_tmr_d   = DIG_LOAD;
          end
        end
        // T_DLY spans exactly TX_DIG_DLY cycles: leave on the cycle the count would hit zero.
        T_DLY: begin
          if (tx_tmr_q <= tmr_t'(1)) begin
            tx_state_d = T_DIG;
            tx_tmr_d   = '0;
          end else begin
            tx_tmr_d = tx_tmr_q - tmr_t'(1);
          end
        end
        T_DIG: if (!tx_ds_s) tx_state_d = T_RDY;
        T_RDY: ;
        default: begin
          tx_state_d = T_RESET;
          tx_tmr_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge reconfig_clk) begin
    if (reconfig_reset) begin
      tx_state_q <= T_RESET;
      tx_tmr_q   <= '0;
      tx_ar_q    <= 1'b1;
      tx_dr_q    <= 1'b1;
      tx_ready_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tmr_q   <= tx_tmr_d;
      tx_ar_q    <= tx_state_d inside {T_RESET, T_WAIT};
      tx_dr_q    <= !(tx_state_d inside {T_DIG, T_RDY});
      tx_ready_q <= (tx_state_d == T_RDY);
    end
  end

  // Reset request outranks lockedtodata loss, which outranks the watchdog.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tmr_d   = rx_tmr_q;
    if (phy.rx_rst_req) begin
      rx_state_d = R_RESET;
      rx_tmr_d   = '0;
    end else if (rx_ltd_loss) begin
      rx_state_d = R_LTD;
      rx_tmr_d   = '0;
    end else if (rx_wd_to) begin
      rx_state_d = R_RESET;
      rx_tmr_d   = '0;
    end else begin
      case (rx_state_q)
        R_RESET: begin
          if (rx_tmr_q == MIN_LAST) begin
            rx_state_d = R_WAIT;
            rx_tmr_d   = '0;
          end else begin
            rx_tmr_d = sat_inc(rx_tmr_q);
          end
        end
        R_WAIT: if (!rx_cal_s && rx_as_s) rx_state_d = R_ANA;
        R_ANA: begin
          if (!rx_as_s) begin
            rx_state_d = R_LTD;
            rx_tmr_d   = '0;
          end
        end
        R_LTD: begin
          if (!ltd_s) begin
            rx_tmr_d = '0;
          end else if (rx_tmr_q == LTD_LAST) begin
            rx_state_d = R_DIG;
            rx_tmr_d   = '0;
          end else begin
            rx_tmr_d = sat_inc(rx_tmr_q);
          end
        end
        R_DIG: if (!rx_ds_s) rx_state_d = R_RDY;
        R_RDY: ;
        default: begin
          rx_state_d = R_RESET;
          rx_tmr_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge reconfig_clk) begin
    if (reconfig_reset) begin
      rx_state_q <= R_RESET;
      rx_tmr_q   <= '0;
      rx_ar_q    <= 1'b1;
      rx_dr_q    <= 1'b1;
      rx_ready_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_tmr_q   <= rx_tmr_d;
      rx_ar_q    <= rx_state_d inside {R_RESET, R_WAIT};
      rx_dr_q    <= !(rx_state_d inside {R_DIG, R_RDY});
      rx_ready_q <= (rx_state_d == R_RDY);
    end
  end

`ifdef XCVR_RST_STAT_TIMEOUT_EN
  localparam tmr_t WD_LAST = tmr_t'(STAT_TIMEOUT - 1);

  tmr_t tx_wd_q, rx_wd_q;
  logic stat_err_q;
  logic tx_watched, rx_watched, tx_wd_fire, rx_wd_fire;

  assign tx_watched = tx_state_q inside {T_WAIT, T_ANA, T_DIG};
  assign rx_watched = rx_state_q inside {R_WAIT, R_ANA, R_DIG};
  assign tx_wd_to   = tx_watched && (tx_wd_q == WD_LAST);
  assign rx_wd_to   = rx_watched && (rx_wd_q == WD_LAST);
  assign tx_wd_fire = tx_wd_to && !tx_abort;
  assign rx_wd_fire = rx_wd_to && !phy.rx_rst_req && !rx_ltd_loss;

  always_ff @(posedge reconfig_clk) begin
    if (reconfig_reset) begin
      tx_wd_q    <= '0;
      rx_wd_q    <= '0;
      stat_err_q <= 1'b0;
    end else begin
      tx_wd_q <= (tx_state_d != tx_state_q || !tx_watched) ? '0 : sat_inc(tx_wd_q);
      rx_wd_q <= (rx_state_d != rx_state_q || !rx_watched) ? '0 : sat_inc(rx_wd_q);
      if (tx_wd_fire || rx_wd_fire) stat_err_q <= 1'b1;
    end
  end

  assign phy.stat_err = stat_err_q;
`else
  assign tx_wd_to     = 1'b0;
  assign rx_wd_to     = 1'b0;
  assign phy.stat_err = 1'b0;
`endif

  assign phy.tx_analogreset  = tx_ar_q;
  assign phy.tx_digitalreset = tx_dr_q;
  assign phy.tx_ready        = tx_ready_q;
  assign phy.rx_analogreset  = rx_ar_q;
  assign phy.rx_digitalreset = rx_dr_q;
  assign phy.rx_ready        = rx_ready_q;

endmodule

// File: tb/tb_xcvr_reset_seq.sv
// tb/tb_xcvr_reset_seq.sv - self-checking bench for xcvr_reset_seq
module tb_xcvr_reset_seq;

  logic reconfig_clk = 1'b0;
  logic reconfig_reset;

  xcvr_reset_seq_if phy_if ();

  xcvr_reset_seq dut (
    .reconfig_clk   (reconfig_clk),
    .reconfig_reset (reconfig_reset),
    .phy            (phy_if.master)
  );

  always #5 reconfig_clk = ~reconfig_clk;

  // vin  = {pll, tx_req, rx_req, tx_cal, rx_cal, tx_as, tx_ds, rx_as, rx_ds, ltd}
  // vexp = {tx_ar, tx_dr, rx_ar, rx_dr, tx_rdy, rx_rdy, stat_err}
  typedef struct {
    int         adv;
    logic [9:0] vin;
    logic [6:0] vexp;
  } vec_t;

  vec_t tbl [20];
  int   errors = 0;
  int   checks = 0;

  task automatic step(input int n);
    repeat (n) @(posedge reconfig_clk);
    #1;
  endtask

  task automatic set_in(input logic [9:0] v);
    {phy_if.pll_locked, phy_if.tx_rst_req, phy_if.rx_rst_req, phy_if.tx_cal_busy,
     phy_if.rx_cal_busy, phy_if.tx_analogreset_stat, phy_if.tx_digitalreset_stat,
     phy_if.rx_analogreset_stat, phy_if.rx_digitalreset_stat,
     phy_if.rx_is_lockedtodata} = v;
  endtask

  function automatic logic [6:0] outs();
    return {phy_if.tx_analogreset, phy_if.tx_digitalreset, phy_if.rx_analogreset,
            phy_if.rx_digitalreset, phy_if.tx_ready, phy_if.rx_ready, phy_if.stat_err};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // PHY that acknowledges each reset level immediately; returns the edge count at which each ready rose.
  task automatic mirror_until(input int budget, output int tx_n, output int rx_n);
    int n;
    n = 0;
    tx_n = 0;
    rx_n = 0;
    while ((tx_n == 0 || rx_n == 0) && n < budget) begin
      phy_if.tx_analogreset_stat  = phy_if.tx_analogreset;
      phy_if.tx_digitalreset_stat = phy_if.tx_digitalreset;
      phy_if.rx_analogreset_stat  = phy_if.rx_analogreset;
      phy_if.rx_digitalreset_stat = phy_if.rx_digitalreset;
      step(1);
      n++;
      if (phy_if.tx_ready && tx_n == 0) tx_n = n;
      if (phy_if.rx_ready && rx_n == 0) rx_n = n;
    end
  endtask

  initial begin
    int tx_n, rx_n;
    logic [6:0] exp_to, exp_late;

    tbl[0]  = '{99,   10'b1000011110, 7'b1111000};
    tbl[1]  = '{1,    10'b1000011110, 7'b1111000};
    tbl[2]  = '{1,    10'b1000011110, 7'b0101000};
    tbl[3]  = '{5,    10'b1000011110, 7'b0101000};
    tbl[4]  = '{2,    10'b1000001011, 7'b0101000};
    tbl[5]  = '{1,    10'b1000001011, 7'b0101000};
    tbl[6]  = '{19,   10'b1000001011, 7'b0101000};
    tbl[7]  = '{1,    10'b1000001011, 7'b0001000};
    tbl[8]  = '{5,    10'b1000001011, 7'b0001000};
    tbl[9]  = '{2,    10'b1000000011, 7'b0001000};
    tbl[10] = '{1,    10'b1000000011, 7'b0001100};
    tbl[11] = '{3969, 10'b1000000011, 7'b0001100};
    tbl[12] = '{1,    10'b1000000010, 7'b0001100};
    tbl[13] = '{1,    10'b1000000011, 7'b0001100};
    tbl[14] = '{1,    10'b1000000011, 7'b0001100};
    tbl[15] = '{3999, 10'b1000000011, 7'b0001100};
    tbl[16] = '{1,    10'b1000000011, 7'b0000100};
    tbl[17] = '{5,    10'b1000000011, 7'b0000100};
    tbl[18] = '{2,    10'b1000000001, 7'b0000100};
    tbl[19] = '{1,    10'b1000000001, 7'b0000110};

    reconfig_reset = 1'b1;
    set_in(10'b0000011110);
    step(3);
    check("reset_state", outs(), 7'b1111000);
    reconfig_reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      set_in(tbl[i].vin);
      step(tbl[i].adv);
      check($sformatf("vec%0d", i), outs(), tbl[i].vexp);
    end

    // lockedtodata lost in R_RDY: back to R_LTD with analog reset still released
    set_in(10'b1000000000);
    step(2);
    check("ltd_drop_pre", outs(), 7'b0000110);
    step(1);
    check("ltd_drop", outs(), 7'b0001100);
    set_in(10'b1000000011);
    step(4001);
    check("ltd_rerun_pre", outs(), 7'b0001100);
    step(1);
    check("ltd_rerun_dig", outs(), 7'b0000100);
    set_in(10'b1000000001);
    step(3);
    check("ltd_rerun_rdy", outs(), 7'b0000110);

    // tx_rst_req held, then released: full minimum reset count restarts
    set_in(10'b1100011001);
    step(1);
    check("tx_req_abort", outs(), 7'b1100010);
    step(4);
    check("tx_req_hold", outs(), 7'b1100010);
    set_in(10'b1000011001);
    step(100);
    check("tx_req_min_cnt", outs(), 7'b1100010);
    step(1);
    check("tx_req_ana", outs(), 7'b0100010);
    set_in(10'b1000001001);
    step(9);
    check("tx_in_dly", outs(), 7'b0100010);
    // pll loss while in T_DLY
    set_in(10'b0000001001);
    step(2);
    check("pll_loss_pre", outs(), 7'b0100010);
    step(1);
    check("pll_loss_abort", outs(), 7'b1100010);

    phy_if.pll_locked = 1'b1;
    mirror_until(1000, tx_n, rx_n);
    check("tx_recovered", outs(), 7'b0000110);

    // reconfig_reset with both sides ready, then full replay
    reconfig_reset = 1'b1;
    step(1);
    check("rst_pulse", outs(), 7'b1111000);
    reconfig_reset = 1'b0;
    mirror_until(6000, tx_n, rx_n);
    check_int("replay_tx_ready_edge", tx_n, 127);
    check_int("replay_rx_ready_edge", rx_n, 4107);

    // rx_rst_req and lockedtodata loss seen on the same edge: request wins
    phy_if.rx_is_lockedtodata = 1'b0;
    step(2);
    phy_if.rx_rst_req = 1'b1;
    step(1);
    check("rx_req_priority", outs(), 7'b0011100);
    phy_if.rx_is_lockedtodata  = 1'b1;
    phy_if.rx_analogreset_stat = 1'b1;
    step(2);
    phy_if.rx_rst_req = 1'b0;
    step(1100);
    check("ana_stuck_pre", outs(), 7'b0001100);
`ifdef XCVR_RST_STAT_TIMEOUT_EN
    exp_to   = 7'b0011101;
    exp_late = 7'b0001101;
`else
    exp_to   = 7'b0001100;
    exp_late = 7'b0001100;
`endif
    step(1);
    check("ana_stuck_timeout", outs(), exp_to);
    step(500);
    check("ana_stuck_late", outs(), exp_late);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xcvr_reset_seq.md
Name: xcvr_reset_seq

Overview:
- Reset sequencer for one H-tile native PHY channel (64-bit PMA-direct, 1 lane).
- Drives tx/rx analog and digital resets in the vendor-required order.
- Gates each reset step on PLL lock, cal_busy, the *_reset_stat acknowledgements and rx_is_lockedtodata.
- Sits beside the PHY in qsfp_xcvr_test and runs on the reconfig clock domain.

Parameters:
- SYNC_STAGES, 2: synchroniser depth on all PHY status inputs.
- MIN_RST_CYCLES, 100: minimum cycles the resets stay asserted after entering a *_RESET state.
- TX_DIG_DLY, 20: cycles between tx analog release acknowledgement and tx digital release.
- RX_LTD_DLY, 4000: cycles rx_is_lockedtodata must stay continuously high before rx digital release.
- STAT_TIMEOUT, 1000: handshake timeout cycles; used only with the optional feature.

Ports:
- reconfig_clk  in  1  block clock.
- reconfig_reset  in  1  synchronous active-high reset.
- pll_locked  in  1  async; TX PLL lock.
- tx_rst_req  in  1  sync level; forces TX restart while high.
- rx_rst_req  in  1  sync level; forces RX restart while high.
- tx_cal_busy, rx_cal_busy  in  1 each  async.
- tx_analogreset_stat, tx_digitalreset_stat, rx_analogreset_stat, rx_digitalreset_stat  in  1 each  async.
- rx_is_lockedtodata  in  1  async.
- tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset  out  1 each  registered PHY resets.
- tx_ready, rx_ready  out  1 each  registered; link side usable.
- stat_err  out  1  sticky handshake-timeout flag; constant 0 without the optional feature.

Behaviour:
- All async inputs pass through SYNC_STAGES flops before use. Latency figures below count from the synchronised value.
- Reset values:
  - all four PHY resets = 1
  - tx_ready = 0, rx_ready = 0, stat_err = 0
  - both FSMs in *_RESET; timers cleared.
- All outputs are registered and decoded from the state register plus one flop.
- TX FSM:
  - T_RESET: both tx resets = 1. Count MIN_RST_CYCLES. Then go to T_WAIT.
  - T_WAIT: leave when pll_locked & !tx_cal_busy & tx_analogreset_stat; go to T_ANA.
  - T_ANA: tx_analogreset = 0. Wait for tx_analogreset_stat = 0, then load the timer with TX_DIG_DLY and go to T_DLY.
  - T_DLY: timer reaches 0, then T_DIG.
  - T_DIG: tx_digitalreset = 0. Wait for tx_digitalreset_stat = 0, then T_RDY.
  - T_RDY: tx_ready = 1.
- TX abort: from any state except T_RESET, pll_locked = 0 or tx_rst_req = 1 returns to T_RESET on the next edge. tx_ready drops in the same edge.
- RX FSM:
  - R_RESET: both rx resets = 1. Count MIN_RST_CYCLES, then R_WAIT.
  - R_WAIT: leave when !rx_cal_busy & rx_analogreset_stat; go to R_ANA.
  - R_ANA: rx_analogreset = 0. Wait for rx_analogreset_stat = 0, then R_LTD.
  - R_LTD: timer counts up while lockedtodata = 1 and clears when it is 0. Reaching RX_LTD_DLY goes to R_DIG.
  - R_DIG: rx_digitalreset = 0. Wait for rx_digitalreset_stat = 0, then R_RDY.
  - R_RDY: rx_ready = 1.
- RX abort rules:
  - Loss of lockedtodata in R_DIG or R_RDY goes to R_LTD: rx_digitalreset re-asserted and rx_ready = 0; rx_analogreset stays 0.
  - rx_rst_req = 1 goes to R_RESET from any state.
- Simultaneous events:
  - rx_rst_req has priority over loss of lockedtodata.
  - reconfig_reset has priority over everything.
  - TX and RX FSMs are independent; a TX abort does not touch RX.
- Requests held high keep the FSM in *_RESET; the MIN_RST_CYCLES count restarts on release.
- Timer width: clog2 of the maximum of MIN_RST_CYCLES, TX_DIG_DLY, RX_LTD_DLY and STAT_TIMEOUT, plus 1. No wrap: the counter saturates.

Optional Feature:
- Macro: XCVR_RST_STAT_TIMEOUT_EN.
- Defined:
  - In T_WAIT, T_ANA, T_DIG, R_WAIT, R_ANA and R_DIG, a per-FSM watchdog counts cycles spent in the state.
  - Reaching STAT_TIMEOUT sets stat_err (sticky until reconfig_reset) and sends that FSM to its *_RESET.
  - The watchdog clears on every state change.
- Undefined: no watchdog logic; FSMs wait indefinitely; stat_err tied 0.

Decomposition:
- Package xcvr_reset_pkg holds:
  - enum types tx_state_t and rx_state_t
  - function clog2
  - default constants for the parameters.
- Natural sub-module: xcvr_reset_sync, a SYNC_STAGES-deep bit synchroniser instanced once per status input (8 instances).

Test Plan:
- PHY model acknowledges stat 5 cycles after each reset edge; pll_locked = 1 at cycle 10. Expected:
  - tx_analogreset falls after MIN_RST_CYCLES + SYNC_STAGES;
  - tx_digitalreset falls exactly TX_DIG_DLY cycles after synchronised tx_analogreset_stat = 0;
  - tx_ready rises once tx_digitalreset_stat = 0.
- rx_is_lockedtodata toggles low for 1 cycle at count 3999 -> timer restarts; rx_digitalreset falls only after 4000 continuous high cycles.
- rx_is_lockedtodata drops in R_RDY -> rx_ready = 0 and rx_digitalreset = 1 on the next edge; rx_analogreset stays 0; R_LTD re-entered.
- pll_locked deasserts in T_DLY -> next edge both tx resets = 1 and tx_ready = 0; RX outputs unchanged.
- reconfig_reset pulsed while both sides are ready -> all resets = 1, readies = 0, stat_err = 0 next edge; full sequence replays.
- With XCVR_RST_STAT_TIMEOUT_EN: hold rx_analogreset_stat = 1 forever -> after 1000 cycles in R_ANA, stat_err = 1 and the RX FSM returns to R_RESET. Without the macro: FSM stays in R_ANA, stat_err = 0.
